// File: rtl/lsu_controller.sv
// Load/store sequencer: one access at a time on a req/gnt/rvalid data port, with lane
// steering, load extension and misalignment flagging. Define LSU_TIMEOUT_EN for the timeout abort.
module lsu_controller #(
   parameter int TIMEOUT_W      = 8,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mem_wr,
   input  logic [2:0]  rd_wr_mem,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata_out,
   output logic        misalign_err,
   output logic        timeout_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [1:0]  dbg_state
);
   // Handshake: dmem_req stays high with stable dmem_* until the cycle dmem_gnt is seen;
   // load data is taken on dmem_rvalid in that grant cycle or any later WAIT cycle.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        we_q, mis_q, tmo_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
   logic        latch, illegal, capture, abort, timeout_hit;
   logic [3:0]  be_lane;
   logic [31:0] wdata_lane, shifted, load_ext;

   assign latch = (state_q == S_IDLE) && start;

   always_comb begin
      illegal = 1'b0;
      case (rd_wr_mem)
         3'd0, 3'd4: illegal = 1'b0;
         3'd1, 3'd5: illegal = addr[0];
         3'd2:       illegal = |addr[1:0];
         default:    illegal = 1'b1;
      endcase
      if (mem_wr && rd_wr_mem[2]) illegal = 1'b1;
   end

   always_comb begin
      be_lane    = 4'b1111;
      wdata_lane = wdata;
      case (rd_wr_mem[1:0])
         2'd0: begin
            be_lane    = 4'b0001 << addr[1:0];
            wdata_lane = {4{wdata[7:0]}};
         end
         2'd1: begin
            be_lane    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted  = dmem_rdata >> {off_q, 3'b000};
      load_ext = shifted;
      case (f3_q)
         3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'd4:    load_ext = {24'b0, shifted[7:0]};
         3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'd5:    load_ext = {16'b0, shifted[15:0]};
         default: ;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   // Counter is zero in the first REQ cycle; the TIMEOUT_CYCLES-th REQ/WAIT cycle aborts.
   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == S_IDLE)
         tmo_cnt_d = '0;
      else if (state_q == S_REQ || state_q == S_WAIT)
         tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_cnt_q <= '0;
      else        tmo_cnt_q <= tmo_cnt_d;
   end

   assign timeout_hit = (state_q == S_REQ || state_q == S_WAIT) && (tmo_cnt_q == TMO_LAST);
`else
   logic [TIMEOUT_W-1:0] cfg_unused;
   assign cfg_unused  = TMO_LAST;
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = illegal ? S_RESP : S_REQ;
         S_REQ: begin
            if (timeout_hit) begin
               abort   = 1'b1;
               state_d = S_RESP;
            end else if (dmem_gnt) begin
               if (we_q) begin
                  state_d = S_RESP;
               end else if (dmem_rvalid) begin
                  capture = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (timeout_hit) begin
               abort   = 1'b1;
               state_d = S_RESP;
            end else if (dmem_rvalid) begin
               capture = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (abort)        rdata_d = '0;
      else if (capture) rdata_d = load_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (latch) begin
            we_q    <= mem_wr;
            f3_q    <= rd_wr_mem;
            off_q   <= addr[1:0];
            addr_q  <= {addr[31:2], 2'b00};
            be_q    <= be_lane;
            wdata_q <= wdata_lane;
            mis_q   <= illegal;
            tmo_q   <= 1'b0;
         end
         if (abort) tmo_q <= 1'b1;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      dmem_req     = (state_q == S_REQ);
      done         = (state_q == S_RESP);
      misalign_err = done & mis_q;
      timeout_err  = done & tmo_q;
      stall        = start & ~done;
      dmem_we      = we_q;
      dmem_addr    = addr_q;
      dmem_be      = be_q;
      dmem_wdata   = wdata_q;
      rdata_out    = rdata_q;
      dbg_state    = state_q;
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Randomized bench for lsu_controller: the driver plays core and memory, a transaction-level
// model predicts each access, and one compare process checks the DUT every cycle.
module tb_lsu_controller;
   // Expected entry: {legal, timeout, we, be[3:0], dmem_addr, dmem_wdata, rdata_out at done}
   localparam int EXP_W  = 103;
   localparam int TO_CYC = 4;
`ifdef LSU_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif
   localparam int LB_RD = TO_ON ? 2 : 3;

   logic        clk, rst_n, start, mem_wr;
   logic [2:0]  rd_wr_mem;
   logic [31:0] addr, wdata;
   logic        stall, done, misalign_err, timeout_err;
   logic [31:0] rdata_out;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [1:0]  dbg_state;

   int n_checks, n_errors;
   int cyc_n, t_start, t_done;
   logic [EXP_W-1:0] exp_q[$];
   bit          chk_en, exp_req_now, exp_done_now;
   logic [31:0] mdl_hold, cmp_hold;
   logic [3:0]  seen_be;
   logic [31:0] seen_addr, seen_wdata;
   logic        last_mis, last_to;

   lsu_controller #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_wr(mem_wr), .rd_wr_mem(rd_wr_mem),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata_out(rdata_out),
      .misalign_err(misalign_err), .timeout_err(timeout_err), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [EXP_W-1:0] model_txn(input logic we, input logic [2:0] f3,
         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
         input logic [31:0] hold, input logic to);
      int n;
      logic legal;
      logic [3:0] be;
      logic [31:0] rep, s, mask, res;
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      case (f3)
         3'd0, 3'd4: legal = 1'b1;
         3'd1, 3'd5: legal = (a % 2 == 0);
         3'd2:       legal = (a % 4 == 0);
         default:    legal = 1'b0;
      endcase
      if (we && f3 >= 3'd4) legal = 1'b0;
      be = 4'(((1 << n) - 1) << a[1:0]);
      for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % n) +: 8];
      s    = word >> (8 * a[1:0]);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      res  = s & mask;
      if (f3 < 3'd4 && n < 4 && s[8*n-1]) res = res | ~mask;
      if (to)                res = 32'h0;
      else if (!legal || we) res = hold;
      return {legal, to, we, be, {a[31:2], 2'b00}, rep, res};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic scramble();
      mem_wr    = 1'($urandom_range(0, 1));
      rd_wr_mem = 3'($urandom_range(0, 7));
      addr      = $urandom;
      wdata     = $urandom;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         start = 1'b0; exp_req_now = 1'b0; exp_done_now = 1'b0;
         dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      end
   endtask

   // gd: REQ cycles before the grant cycle; rd: cycles from grant to rvalid (0 = same cycle)
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int gd,
                          input int rd);
      logic [EXP_W-1:0] e;
      logic legal, to;
      int fin_idx;
      step();
      start = 1'b1; mem_wr = we; rd_wr_mem = f3; addr = a; wdata = wd;
      dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      exp_req_now = 1'b0; exp_done_now = 1'b0;
      t_start = cyc_n;
      e       = model_txn(we, f3, a, wd, word, mdl_hold, 1'b0);
      legal   = e[EXP_W-1];
      fin_idx = we ? gd : gd + rd;
      to      = TO_ON && legal && (fin_idx >= TO_CYC - 1);
      if (to) e = model_txn(we, f3, a, wd, word, mdl_hold, 1'b1);
      exp_q.push_back(e);
      mdl_hold = e[31:0];
      if (legal) begin
         for (int c = 0; c <= fin_idx; c++) begin
            step();
            scramble();
            exp_req_now = (c <= gd);
            dmem_gnt    = (c == gd);
            if (!we && c == gd + rd) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = word;
            end else begin
               dmem_rvalid = (c < gd || we) ? 1'($urandom_range(0, 1)) : 1'b0;
               dmem_rdata  = $urandom;
            end
            if (to && c == TO_CYC - 1) break;
         end
      end
      step();
      scramble();
      dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      exp_req_now = 1'b0; exp_done_now = 1'b1;
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (chk_en) begin
         chk("stall", 32'(stall), 32'(start & ~exp_done_now));
         chk("done", 32'(done), 32'(exp_done_now));
         chk("dmem_req", 32'(dmem_req), 32'(exp_req_now));
         if (dmem_req) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL req_no_txn: got dmem_req=1 expected no access (cycle %0d)", cyc_n);
            end else begin
               e = exp_q[0];
               chk("dmem_addr", dmem_addr, e[95:64]);
               chk("dmem_be", 32'(dmem_be), 32'(e[99:96]));
               chk("dmem_we", 32'(dmem_we), 32'(e[100]));
               if (e[100]) chk("dmem_wdata", dmem_wdata, e[63:32]);
               seen_be = dmem_be; seen_addr = dmem_addr; seen_wdata = dmem_wdata;
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL done_no_txn: got done=1 expected idle (cycle %0d)", cyc_n);
            end else begin
               e = exp_q.pop_front();
               chk("misalign_err", 32'(misalign_err), 32'(!e[102]));
               chk("timeout_err", 32'(timeout_err), 32'(e[101]));
               chk("rdata_out_done", rdata_out, e[31:0]);
               cmp_hold = e[31:0];
               last_mis = misalign_err;
               last_to  = timeout_err;
               t_done   = cyc_n;
            end
         end else begin
            chk("misalign_idle", 32'(misalign_err), 32'h0);
            chk("timeout_idle", 32'(timeout_err), 32'h0);
            chk("rdata_out_hold", rdata_out, cmp_hold);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0; n_errors = 0; chk_en = 1'b0;
      exp_req_now = 1'b0; exp_done_now = 1'b0;
      mdl_hold = '0; cmp_hold = '0; t_start = 0; t_done = 0;
      seen_be = '0; seen_addr = '0; seen_wdata = '0; last_mis = 1'b0; last_to = 1'b0;
      rst_n = 1'b0; start = 1'b0; mem_wr = 1'b0; rd_wr_mem = '0; addr = '0; wdata = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dmem_req", 32'(dmem_req), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_errs", 32'({misalign_err, timeout_err}), 32'h0);
      chk("rst_rdata_out", rdata_out, 32'h0);
      chk("rst_dmem_fields", 32'({dmem_we, dmem_be}), 32'h0);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      chk("rst_dmem_wdata", dmem_wdata, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk_en = 1'b1;

      // SW, grant in first REQ cycle
      run_txn(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 0);
      idle(1);
      chk("sw_be", 32'(seen_be), 32'hF);
      chk("sw_addr", seen_addr, 32'h0000_0104);
      chk("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
      chk("sw_latency", 32'(t_done - t_start), 32'd2);

      // SB to the top byte lane
      run_txn(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1, 0);
      idle(1);
      chk("sb_be", 32'(seen_be), 32'h8);
      chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);
      chk("sb_addr", seen_addr, 32'h0000_0100);

      // LB / LBU with delayed rvalid
      run_txn(1'b0, 3'd0, 32'h0000_0201, 32'h0, 32'h0000_F000, 0, LB_RD);
      idle(1);
      chk("lb_rdata", rdata_out, 32'hFFFF_FFF0);
      run_txn(1'b0, 3'd4, 32'h0000_0201, 32'h0, 32'h0000_F000, 0, LB_RD);
      idle(1);
      chk("lbu_rdata", rdata_out, 32'h0000_00F0);

      // misaligned LH and illegal funct3
      run_txn(1'b0, 3'd1, 32'h0000_0203, 32'h0, 32'h1234_5678, 0, 0);
      idle(1);
      chk("lh_mis_err", 32'(last_mis), 32'h1);
      chk("lh_mis_latency", 32'(t_done - t_start), 32'd1);
      chk("lh_mis_rdata", rdata_out, 32'h0000_00F0);
      run_txn(1'b0, 3'd3, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 0);
      idle(1);
      chk("f3_3_mis_err", 32'(last_mis), 32'h1);

      // grant held off for 5 cycles, back-to-back with a load
      run_txn(1'b1, 3'd2, 32'h0000_0040, 32'h1357_9BDF, 32'h0, 5, 0);
      run_txn(1'b0, 3'd5, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 2, 1);
      idle(2);

`ifdef LSU_TIMEOUT_EN
      run_txn(1'b1, 3'd2, 32'h0000_0080, 32'hCAFE_F00D, 32'h0, 50, 0);
      idle(1);
      chk("timeout_err", 32'(last_to), 32'h1);
      chk("timeout_rdata", rdata_out, 32'h0);
`endif

      for (int i = 0; i < 200; i++) begin
         logic we;
         logic [2:0] f3;
         logic [31:0] a;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run_txn(we, f3, a, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 3));
         idle($urandom_range(0, 2));
      end

      // reset in the middle of a request
      step();
      chk_en = 1'b0;
      start = 1'b1; mem_wr = 1'b1; rd_wr_mem = 3'd2; addr = 32'h0000_0300; wdata = $urandom;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; exp_req_now = 1'b0; exp_done_now = 1'b0;
      step();
      chk("req_before_reset", 32'(dmem_req), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("req_async_drop", 32'(dmem_req), 32'h0);
      chk("done_in_reset", 32'(done), 32'h0);
      chk("rdata_in_reset", rdata_out, 32'h0);
      step();
      start = 1'b0;
      step();
      rst_n = 1'b1;
      mdl_hold = '0; cmp_hold = '0;
      step();
      chk_en = 1'b1;

      run_txn(1'b0, 3'd1, 32'h0000_0302, 32'h0, 32'h8765_4321, 1, 0);
      idle(3);
      chk("post_reset_lh", rdata_out, 32'hFFFF_8765);
      chk("exp_q_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
